// File: rtl/gsim_b_encoder_pkg.sv
// gsim_b_encoder_pkg
//   Shared types and constants for the GSIM b-encoder. The encoder takes an x
//   vector and recomputes b = A*x for the fixed banded GSIM matrix.
//   The matrix has diagonal 20, offset +-1 = -13, offset +-2 = +6 and
//   offset +-3 = -1.
//   Contents:
//     N      vector length (16, so counters are 4 bits wide)
//     XW     x width, signed Q16.16
//     BW     b width, signed integer
//     FRAC   fractional bits of x dropped when forming b
//     ACCW   accumulator width
//     state_t  FSM encoding S_IDLE / S_LOAD / S_CALC
package gsim_b_encoder_pkg;
    localparam int N    = 16;
    localparam int CW   = 4;
    localparam int XW   = 32;
    localparam int BW   = 16;
    localparam int FRAC = 16;
    localparam int ACCW = 40;

    typedef logic signed [XW-1:0]   x_t;
    typedef logic signed [BW-1:0]   b_t;
    typedef logic signed [ACCW-1:0] acc_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2
    } state_t;
endpackage

// File: rtl/gsim_b_encoder_if.sv
// gsim_b_encoder_if
//   This interface bundles the x input stream and the b output stream of the encoder.
//   Signals:
//     in_en     x_in valid this cycle (index 0 first)
//     x_in      x element, signed Q16.16
//     out_valid b_out valid. It is high for N consecutive cycles per vector.
//     b_out     b element, signed integer
//     busy      high while rows are being computed. in_en is ignored while it is high.
//     sat       the current b_out element was clipped
//   The master modport is used by the producer of x. The slave modport is used by the encoder.
interface gsim_b_encoder_if;
    import gsim_b_encoder_pkg::*;

    logic in_en;
    x_t   x_in;
    logic out_valid;
    b_t   b_out;
    logic busy;
    logic sat;

    modport master (output in_en, x_in, input out_valid, b_out, busy, sat);
    modport slave  (input in_en, x_in, output out_valid, b_out, busy, sat);
endinterface

// File: rtl/gsim_b_encoder_row_mac.sv
// gsim_b_encoder_row_mac
//   This block is purely combinational. It computes one row of A*x from seven taps,
//   tap[0] = x[row-3] through tap[6] = x[row+3]. The caller has already zeroed
//   any tap that falls outside the vector.
//   All products are built from shifts and adds:
//     20 = 16 + 4
//     13 = 8 + 4 + 1
//     6  = 4 + 2
//   Every term is sign-extended to ACCW bits.
//   Macro GSIM_B_ROUND_EN:
//     defined   -> round half up, (acc + 2^15) >>> 16, before saturation
//     undefined -> plain arithmetic shift (floor)
//   Ports:
//     tap  in   7 x XW   row taps
//     b    out  BW       saturated row result
//     sat  out  1        result was clipped
module gsim_b_encoder_row_mac
    import gsim_b_encoder_pkg::*;
(
    input  x_t   tap [7],
    output b_t   b,
    output logic sat
);
    localparam acc_t B_MAX = acc_t'((2 ** (BW - 1)) - 1);
    localparam acc_t B_MIN = -acc_t'(2 ** (BW - 1));

    acc_t c0, p1, p2, p3, acc, acc_r, shifted;

    always_comb begin
        c0 = acc_t'(tap[3]);
        p1 = acc_t'(tap[2]) + acc_t'(tap[4]);
        p2 = acc_t'(tap[1]) + acc_t'(tap[5]);
        p3 = acc_t'(tap[0]) + acc_t'(tap[6]);

        acc = (c0 <<< 4) + (c0 <<< 2)
            - ((p1 <<< 3) + (p1 <<< 2) + p1)
            + (p2 <<< 2) + (p2 <<< 1)
            - p3;

`ifdef GSIM_B_ROUND_EN
        acc_r = acc + (acc_t'(1) <<< (FRAC - 1));
`else
        acc_r = acc;
`endif
        shifted = acc_r >>> FRAC;

        if (shifted > B_MAX) begin
            b   = B_MAX[BW-1:0];
            sat = 1'b1;
        end else if (shifted < B_MIN) begin
            b   = B_MIN[BW-1:0];
            sat = 1'b1;
        end else begin
            b   = shifted[BW-1:0];
            sat = 1'b0;
        end
    end
endmodule

// File: rtl/gsim_b_encoder.sv
// gsim_b_encoder
//   This block collects a 16-element x vector and recomputes b = A*x, one row per cycle.
//   It streams b out in row order.
//   Path from input to output:
//     * Row results pass through one pipeline register and then the output register.
//     * out_valid for row 0 therefore rises two cycles after the edge that accepts x[15].
//   Macro GSIM_B_ROUND_EN selects round-half-up. It is applied inside the row MAC.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous, active-high
//     bus    gsim_b_encoder_if.slave: in_en/x_in in; out_valid/b_out/busy/sat out
//
//   state  | meaning
//   S_IDLE | waiting for x[0]
//   S_LOAD | storing x[cnt] on each in_en. Gaps between samples are allowed.
//   S_CALC | computing row 'row' each cycle. in_en is dropped.
module gsim_b_encoder
    import gsim_b_encoder_pkg::*;
(
    input logic             clk,
    input logic             reset,
    gsim_b_encoder_if.slave bus
);
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, row_q;
    x_t              x_buf [N];
    x_t              tap [7];
    logic            accept, calc;
    b_t              mac_b;
    logic            mac_sat;
    logic            pipe_valid, pipe_sat;
    b_t              pipe_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_en) state_d = S_LOAD;
            S_LOAD:  if (bus.in_en && cnt_q == CW'(N - 1)) state_d = S_CALC;
            S_CALC:  if (row_q == CW'(N - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        calc     = 1'b0;
        case (state_q)
            S_IDLE, S_LOAD: accept = bus.in_en;
            S_CALC:         calc   = 1'b1;
            default:        ;
        endcase
        bus.busy = calc;
    end

    // Taps outside 0..N-1 are zeroed by an index check. They never wrap around.
    always_comb begin
        int idx;
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            idx    = int'(row_q) + k - 3;
            tap[k] = (idx >= 0 && idx < N) ? x_buf[idx[CW-1:0]] : '0;
        end
    end

    gsim_b_encoder_row_mac u_row_mac (
        .tap (tap),
        .b   (mac_b),
        .sat (mac_sat)
    );

    // cnt is 0 in IDLE: it wraps from 15 back to 0. The first accepted sample therefore lands in x_buf[0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            row_q         <= '0;
            for (int i = 0; i < N; i++) x_buf[i] <= '0;
            pipe_valid    <= 1'b0;
            pipe_b        <= '0;
            pipe_sat      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.b_out     <= '0;
            bus.sat       <= 1'b0;
        end else begin
            if (accept) begin
                x_buf[cnt_q] <= bus.x_in;
                cnt_q        <= cnt_q + 1'b1;
            end
            if (calc) begin
                row_q    <= row_q + 1'b1;
                pipe_b   <= mac_b;
                pipe_sat <= mac_sat;
            end
            pipe_valid    <= calc;
            bus.out_valid <= pipe_valid;
            if (pipe_valid) begin
                bus.b_out <= pipe_b;
                bus.sat   <= pipe_sat;
            end else begin
                bus.sat   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gsim_b_encoder.sv
// tb_gsim_b_encoder
//   This is a directed bench for gsim_b_encoder. The expected b vectors are worked out by hand.
//   A small integer reference model, built on multiplies, covers the saturation and random cases.
module tb_gsim_b_encoder;
    import gsim_b_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    gsim_b_encoder_if bus ();

    gsim_b_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int got_b [16];
    int got_s [16];
    int got_n  = 0;
    int busy_n = 0;

    always @(posedge clk) begin
        #1;
        if (bus.out_valid) begin
            if (got_n < 16) begin
                got_b[got_n] = int'(bus.b_out);
                got_s[got_n] = int'(bus.sat);
            end
            got_n++;
        end
        if (bus.busy) busy_n++;
    end

    function automatic int coef(input int d);
        case (d)
            0:       return 20;
            1:       return -13;
            2:       return 6;
            3:       return -1;
            default: return 0;
        endcase
    endfunction

    function automatic void model(input logic [31:0] xv [16], output int eb [16], output int es [16]);
        for (int i = 0; i < 16; i++) begin
            longint acc, q;
            int d;
            acc = 0;
            for (int j = 0; j < 16; j++) begin
                d = (i > j) ? i - j : j - i;
                acc += longint'(coef(d)) * longint'(signed'(xv[j]));
            end
`ifdef GSIM_B_ROUND_EN
            acc += 32768;
`endif
            q = acc >>> 16;
            if (q > 32767)       begin eb[i] = 32767;  es[i] = 1; end
            else if (q < -32768) begin eb[i] = -32768; es[i] = 1; end
            else                 begin eb[i] = int'(q); es[i] = 0; end
        end
    endfunction

    task automatic send_samples(input logic [31:0] xv [16], input int gap_max, input int count);
        int g;
        for (int i = 0; i < count; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                bus.in_en = 1'b0;
                bus.x_in  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            bus.in_en = 1'b1;
            bus.x_in  = xv[i];
        end
    endtask

    task automatic run_vector(input string tag, input logic [31:0] xv [16], input int gap_max, input bit hold);
        int cyc;
        got_n  = 0;
        busy_n = 0;
        send_samples(xv, gap_max, 16);
        @(negedge clk);
        bus.in_en = hold;
        bus.x_in  = 32'h1234_5678;
        check({tag, "/lat0_valid"}, int'(bus.out_valid), 0);
        check({tag, "/lat0_busy"}, int'(bus.busy), 1);
        @(negedge clk);
        check({tag, "/lat1_valid"}, int'(bus.out_valid), 0);
        @(negedge clk);
        check({tag, "/lat2_valid"}, int'(bus.out_valid), 1);
        cyc = 0;
        while (got_n < 16 && cyc < 40) begin
            @(negedge clk);
            bus.in_en = hold && bus.busy;
            cyc++;
        end
        bus.in_en = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "/out_count"}, got_n, 16);
        check({tag, "/busy_cycles"}, busy_n, 16);
    endtask

    task automatic cmp_vec(input string tag, input int eb [16], input int es [16]);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s/b%0d", tag, i), got_b[i], eb[i]);
            check($sformatf("%s/sat%0d", tag, i), got_s[i], es[i]);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "/out_valid"}, int'(bus.out_valid), 0);
        check({tag, "/b_out"}, int'(bus.b_out), 0);
        check({tag, "/busy"}, int'(bus.busy), 0);
        check({tag, "/sat"}, int'(bus.sat), 0);
    endtask

    logic [31:0] xv [16];
    int eb1 [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
    int eb [16];
    int es [16];
    int zs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got_n=%0d", got_n);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) zs[i] = 0;
        bus.in_en = 1'b0;
        bus.x_in  = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // all 1.0
        for (int i = 0; i < 16; i++) xv[i] = 32'h0001_0000;
        run_vector("ones", xv, 0, 1'b0);
        cmp_vec("ones", eb1, zs);
        check("ones/hold_b", int'(bus.b_out), 12);

        // single impulse at x[0]
        for (int i = 0; i < 16; i++) xv[i] = 32'h0;
        xv[0] = 32'h0001_0000;
        for (int i = 0; i < 16; i++) eb[i] = 0;
        eb[0] = 20; eb[1] = -13; eb[2] = 6; eb[3] = -1;
        run_vector("impulse", xv, 0, 1'b0);
        cmp_vec("impulse", eb, zs);

        // all -1.0
        for (int i = 0; i < 16; i++) begin
            xv[i] = 32'hFFFF_0000;
            eb[i] = -eb1[i];
        end
        run_vector("neg_ones", xv, 0, 1'b0);
        cmp_vec("neg_ones", eb, zs);

        // positive full scale
        for (int i = 0; i < 16; i++) xv[i] = 32'h7FFF_0000;
        run_vector("pos_max", xv, 0, 1'b0);
        check("pos_max/b0_hand", got_b[0], 32767);
        check("pos_max/s0_hand", got_s[0], 1);
        check("pos_max/b1_hand", got_b[1], -32767);
        check("pos_max/s1_hand", got_s[1], 0);
        model(xv, eb, es);
        cmp_vec("pos_max", eb, es);

        // negative full scale
        for (int i = 0; i < 16; i++) xv[i] = 32'h8000_0000;
        run_vector("neg_max", xv, 0, 1'b0);
        check("neg_max/b0_hand", got_b[0], -32768);
        check("neg_max/s0_hand", got_s[0], 1);
        check("neg_max/b1_hand", got_b[1], 32767);
        check("neg_max/s1_hand", got_s[1], 1);
        model(xv, eb, es);
        cmp_vec("neg_max", eb, es);

        // 1/32 impulse: rounding versus floor
        for (int i = 0; i < 16; i++) xv[i] = 32'h0;
        xv[0] = 32'h0000_0800;
        run_vector("frac", xv, 0, 1'b0);
`ifdef GSIM_B_ROUND_EN
        check("frac/b0", got_b[0], 1);
        check("frac/b1", got_b[1], 0);
        check("frac/b3", got_b[3], 0);
`else
        check("frac/b0", got_b[0], 0);
        check("frac/b1", got_b[1], -1);
        check("frac/b3", got_b[3], -1);
`endif

        // random vector: gap-free, then with gaps and in_en held during CALC
        for (int i = 0; i < 16; i++) xv[i] = $urandom;
        model(xv, eb, es);
        run_vector("rand_nogap", xv, 0, 1'b0);
        cmp_vec("rand_nogap", eb, es);
        run_vector("rand_gap", xv, 3, 1'b1);
        cmp_vec("rand_gap", eb, es);

        // the extra samples offered during CALC must not have started a new vector
        for (int i = 0; i < 16; i++) xv[i] = 32'h0001_0000;
        run_vector("after_hold", xv, 0, 1'b0);
        cmp_vec("after_hold", eb1, zs);

        // reset after 9 samples
        for (int i = 0; i < 16; i++) xv[i] = 32'h0002_0000;
        send_samples(xv, 0, 9);
        @(negedge clk);
        bus.in_en = 1'b0;
        check("rst_load/pre_b_out", int'(bus.b_out), 12);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_load");
        reset = 1'b0;
        @(negedge clk);

        // reset at row 7 of CALC
        got_n = 0;
        send_samples(xv, 0, 16);
        @(negedge clk);
        bus.in_en = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_calc/pre_valid", int'(bus.out_valid), 1);
        check("rst_calc/pre_busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_calc");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) xv[i] = 32'h0001_0000;
        run_vector("post_rst", xv, 0, 1'b0);
        cmp_vec("post_rst", eb1, zs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
